// File: rtl/ascon_ti_pkg.sv
// ascon_ti_pkg
// Shared definitions for the 3-share threshold-implementation Ascon datapath:
// state geometry, the FSM state enum used by the share recombiner, the lane
// slicing helper and the clamp rule for the requested word count.
package ascon_ti_pkg;

    localparam int W       = 64;
    localparam int LANES   = 5;
    localparam int NSHARES = 3;
    localparam int STATE_W = LANES * W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fsm_state_t;

    // Lane i of a packed state lives at bits [W*i+W-1 : W*i], x0 at the LSBs.
    function automatic logic [W-1:0] lane_slice(input logic [STATE_W-1:0] v,
                                                input logic [2:0]         idx);
        return v[int'(idx) * W +: W];
    endfunction

    // A request of 0 lanes, or more lanes than exist, means "the whole state".
    function automatic logic [2:0] clamp_nwords(input logic [2:0] nwords);
        if (nwords == 3'd0 || int'(nwords) > LANES) begin
            return 3'(LANES);
        end
        return nwords;
    endfunction

endpackage

// File: rtl/ascon_ti_share_reg.sv
// ascon_ti_share_reg
// Register bank holding the three shares of a masked value. Each share lives
// in its own register so that no share is ever combined with another before
// being registered. Shared with the masking front end.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset, zeroes all shares
//   load         capture d0/d1/d2 into the bank
//   clear        zero all shares (load wins if both are high)
//   d0, d1, d2   incoming shares
//   q0, q1, q2   registered shares
module ascon_ti_share_reg #(
    parameter int WIDTH = ascon_ti_pkg::STATE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    output logic [WIDTH-1:0] q0,
    output logic [WIDTH-1:0] q1,
    output logic [WIDTH-1:0] q2
);

    import ascon_ti_pkg::*;

    // One share per register; load has priority so a fresh state is never
    // lost to a simultaneous clear request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q0 <= '0;
            q1 <= '0;
            q2 <= '0;
        end else if (load) begin
            q0 <= d0;
            q1 <= d1;
            q2 <= d2;
        end else if (clear) begin
            q0 <= '0;
            q1 <= '0;
            q2 <= '0;
        end
    end

endmodule

// File: rtl/ascon_ti_unmask.sv
// ascon_ti_unmask
// Output-side share recombiner. Accepts a 3-share 320-bit Ascon state and
// emits the first n unmasked 64-bit lanes word-serially on a valid/ready
// stream. Recombination is split over two registered stages:
//   stage A: p = s0[k] ^ s1[k]        (s2 never enters this stage)
//   stage B: out_data = p ^ s2[p_idx]
// so no combinational cone ever sees all three shares of a bit together.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid / in_ready      shared-state input handshake (ready only in IDLE)
//   in_s0, in_s1, in_s2      the three shares, lane i at bits [W*i+W-1:W*i]
//   in_nwords                lanes to emit from x0; 0 or >LANES means LANES
//   out_valid / out_ready    output word handshake
//   out_data, out_idx        unmasked lane and its index
//   out_last                 final word of the current state
//   busy                     any state other than IDLE
//
// Build option:
//   ASCON_TI_UNMASK_CLR_EN   zero the share registers and p at the last-word
//                            handshake instead of leaving them until reload.
module ascon_ti_unmask #(
    parameter int LANES = ascon_ti_pkg::LANES,
    parameter int W     = ascon_ti_pkg::W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LANES*W-1:0]   in_s0,
    input  logic [LANES*W-1:0]   in_s1,
    input  logic [LANES*W-1:0]   in_s2,
    input  logic [2:0]           in_nwords,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         out_data,
    output logic [2:0]           out_idx,
    output logic                 out_last,
    output logic                 busy
);

    import ascon_ti_pkg::*;

    localparam int SW = LANES * W;

    fsm_state_t     state_q;
    fsm_state_t     state_d;
    logic [SW-1:0]  s0_q;
    logic [SW-1:0]  s1_q;
    logic [SW-1:0]  s2_q;
    logic [2:0]     n_q;
    logic [2:0]     k_q;
    logic [W-1:0]   p_q;
    logic [2:0]     p_idx_q;
    logic           p_v_q;

    logic           stall;
    logic           accept;
    logic           last_hs;
    logic           issue_last;
    logic           share_clr;

    // A held output word freezes the whole pipeline, the lane counter and
    // the FSM, which is what keeps backpressure from dropping or duplicating.
    assign stall      = out_valid && !out_ready;
    assign accept     = in_valid && in_ready;
    assign last_hs    = out_valid && out_ready && out_last;
    assign issue_last = (k_q == n_q - 3'd1);

`ifdef ASCON_TI_UNMASK_CLR_EN
    assign share_clr = last_hs;
`else
    assign share_clr = 1'b0;
`endif

    ascon_ti_share_reg #(
        .WIDTH (SW)
    ) u_shares (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .clear (share_clr),
        .d0    (in_s0),
        .d1    (in_s1),
        .d2    (in_s2),
        .q0    (s0_q),
        .q1    (s1_q),
        .q2    (s2_q)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. RUN leaves once the last lane has been issued into
    // stage A; DRAIN waits until that lane has actually been handed off.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (!stall && issue_last) state_d = DRAIN;
            DRAIN:   if (last_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs. in_ready is masked by rst so nothing can be accepted while
    // the block is held in reset.
    always_comb begin
        in_ready = (state_q == IDLE) && !rst;
        busy     = (state_q != IDLE);
    end

    // Lane counter and latched word count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_q <= '0;
            n_q <= '0;
        end else if (accept) begin
            k_q <= '0;
            n_q <= clamp_nwords(in_nwords);
        end else if (state_q == RUN && !stall) begin
            k_q <= k_q + 3'd1;
        end
    end

    // Stage A: first partial recombination of shares 0 and 1 only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q     <= '0;
            p_idx_q <= '0;
            p_v_q   <= 1'b0;
        end else if (!stall) begin
            if (state_q == RUN) begin
                p_q     <= lane_slice(s0_q, k_q) ^ lane_slice(s1_q, k_q);
                p_idx_q <= k_q;
                p_v_q   <= 1'b1;
            end else begin
                p_v_q <= 1'b0;
                if (share_clr) begin
                    p_q <= '0;
                end
            end
        end
    end

    // Stage B: fold in share 2 from the registered partial result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
        end else if (!stall) begin
            if (p_v_q) begin
                out_data  <= p_q ^ lane_slice(s2_q, p_idx_q);
                out_idx   <= p_idx_q;
                out_last  <= (p_idx_q == n_q - 3'd1);
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ascon_ti_unmask.sv
// tb_ascon_ti_unmask
// Self-checking bench for ascon_ti_unmask. The reference model keeps the
// three shares as arrays of 64-bit lanes; each expected word is simply the
// XOR of the three shares of that lane, expected on the cycle given by the
// 2-cycle latency plus any backpressure applied so far.
// Honours ASCON_TI_UNMASK_CLR_EN when checking the retained share registers.
module tb_ascon_ti_unmask;

    localparam int NL = 5;
    localparam int LW = 64;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid;
    logic               in_ready;
    logic [NL*LW-1:0]   in_s0;
    logic [NL*LW-1:0]   in_s1;
    logic [NL*LW-1:0]   in_s2;
    logic [2:0]         in_nwords;
    logic               out_valid;
    logic               out_ready;
    logic [LW-1:0]      out_data;
    logic [2:0]         out_idx;
    logic               out_last;
    logic               busy;

    int checks = 0;
    int errors = 0;

    // Reference shares, one 64-bit word per lane.
    logic [LW-1:0] m0 [NL];
    logic [LW-1:0] m1 [NL];
    logic [LW-1:0] m2 [NL];

    always #5 clk = ~clk;

    ascon_ti_unmask #(
        .LANES (NL),
        .W     (LW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_s0     (in_s0),
        .in_s1     (in_s1),
        .in_s2     (in_s2),
        .in_nwords (in_nwords),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy)
    );

    // One comparison point: counts it, and counts and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    // Random plaintext lanes D, split into three random-looking shares.
    task automatic makeRandomShares();
        logic [63:0] d;
        for (int i = 0; i < NL; i++) begin
            d     = rand64();
            m0[i] = rand64();
            m1[i] = rand64();
            m2[i] = d ^ m0[i] ^ m1[i];
        end
    endtask

    // Present the model shares, then follow the output stream word by word.
    // stall_word/stall_len hold out_ready low on one word; abort_at asserts
    // reset when that word index shows up (-1 disables either feature).
    task automatic applyStimulus(input int nw, input int stall_word,
                                 input int stall_len, input int abort_at);
        int n;
        int w;
        int delay;
        int stall_left;
        n          = (nw == 0 || nw > NL) ? NL : nw;
        w          = 0;
        delay      = 0;
        stall_left = stall_len;

        @(negedge clk);
        for (int i = 0; i < NL; i++) begin
            in_s0[i*LW +: LW] = m0[i];
            in_s1[i*LW +: LW] = m1[i];
            in_s2[i*LW +: LW] = m2[i];
        end
        in_nwords = 3'(nw);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        checkOutput("in_ready_idle", 64'(in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_s0    = {$urandom, $urandom, $urandom, $urandom, $urandom,
                    $urandom, $urandom, $urandom, $urandom, $urandom};
        in_s1    = ~in_s0;
        in_s2    = {in_s0[159:0], in_s0[319:160]};
        checkOutput("busy_after_accept", 64'(busy), 64'd1);
        checkOutput("in_ready_busy", 64'(in_ready), 64'd0);

        for (int e = 0; e < 80 && w < n; e++) begin
            if (e > 0) @(negedge clk);
            if (out_valid) begin
                checkOutput($sformatf("w%0d_cycle", w), 64'(e), 64'(w + 2 + delay));
                checkOutput($sformatf("w%0d_data", w), out_data, m0[w] ^ m1[w] ^ m2[w]);
                checkOutput($sformatf("w%0d_idx", w), 64'(out_idx), 64'(w));
                checkOutput($sformatf("w%0d_last", w), 64'(out_last), 64'(w == n - 1));
                if (w == abort_at) begin
                    rst = 1'b1;
                    #1;
                    checkOutput("abort_valid_drop", 64'(out_valid), 64'd0);
                    checkOutput("abort_busy", 64'(busy), 64'd0);
                    checkOutput("abort_in_ready_in_reset", 64'(in_ready), 64'd0);
                    repeat (2) @(negedge clk);
                    rst = 1'b0;
                    out_ready = 1'b1;
                    for (int j = 0; j < 4; j++) begin
                        @(negedge clk);
                        checkOutput("abort_no_words", 64'(out_valid), 64'd0);
                        checkOutput("abort_in_ready", 64'(in_ready), 64'd1);
                        checkOutput("abort_idle", 64'(busy), 64'd0);
                    end
                    return;
                end
                if (w == stall_word && stall_left > 0) begin
                    out_ready = 1'b0;
                    stall_left--;
                    delay++;
                end else begin
                    out_ready = 1'b1;
                    if (w == n - 1) begin
                        checkOutput("in_ready_before_last_hs", 64'(in_ready), 64'd0);
                    end
                    w++;
                end
            end
        end
        if (w < n) begin
            checkOutput("word_timeout", 64'(w), 64'(n));
            out_ready = 1'b1;
            return;
        end
        @(negedge clk);
        checkOutput("in_ready_after_last", 64'(in_ready), 64'd1);
        checkOutput("busy_after_last", 64'(busy), 64'd0);
        checkOutput("no_extra_word", 64'(out_valid), 64'd0);
    endtask

    initial begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_s0     = '0;
        in_s1     = '0;
        in_s2     = '0;
        in_nwords = 3'd0;

        // Reset state while held in reset, then idle after release.
        repeat (2) @(negedge clk);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_out_data", out_data, 64'd0);
        checkOutput("rst_out_idx", 64'(out_idx), 64'd0);
        checkOutput("rst_out_last", 64'(out_last), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_in_ready", 64'(in_ready), 64'd1);
        checkOutput("idle_busy", 64'(busy), 64'd0);

        $display("[TB] s2-only state, 5 words");
        for (int i = 0; i < NL; i++) begin
            m0[i] = '0;
            m1[i] = '0;
            m2[i] = 64'h0123456789ABCDE0 + 64'(i);
        end
        applyStimulus(5, -1, 0, -1);

        $display("[TB] random shares, 2 words");
        makeRandomShares();
        applyStimulus(2, -1, 0, -1);

        $display("[TB] backpressure of 3 cycles on word 1");
        applyStimulus(5, 1, 3, -1);

        $display("[TB] nwords 0 and 7 clamp to 5");
        makeRandomShares();
        applyStimulus(0, -1, 0, -1);
        makeRandomShares();
        applyStimulus(7, -1, 0, -1);

        $display("[TB] reset after word 1, then a fresh state");
        makeRandomShares();
        applyStimulus(5, -1, 0, 2);
        makeRandomShares();
        applyStimulus(5, -1, 0, -1);

        $display("[TB] random counts and stalls");
        for (int r = 0; r < 8; r++) begin
            makeRandomShares();
            applyStimulus(int'($urandom_range(0, 7)), int'($urandom_range(0, 4)),
                          int'($urandom_range(0, 4)), -1);
        end

        // Share bank contents after the final handshake.
        for (int i = 0; i < NL; i++) begin
`ifdef ASCON_TI_UNMASK_CLR_EN
            checkOutput($sformatf("share0_l%0d", i), dut.s0_q[i*LW +: LW], 64'd0);
            checkOutput($sformatf("share1_l%0d", i), dut.s1_q[i*LW +: LW], 64'd0);
            checkOutput($sformatf("share2_l%0d", i), dut.s2_q[i*LW +: LW], 64'd0);
`else
            checkOutput($sformatf("share0_l%0d", i), dut.s0_q[i*LW +: LW], m0[i]);
            checkOutput($sformatf("share1_l%0d", i), dut.s1_q[i*LW +: LW], m1[i]);
            checkOutput($sformatf("share2_l%0d", i), dut.s2_q[i*LW +: LW], m2[i]);
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
